// File: rtl/act_sched_pkg.sv
// Shared constants and state encoding for the ReLU activation-unit scheduler.
// Select codes match what the activation unit's input mux expects.
package act_sched_pkg;

    localparam int LenWidthDef = 8;

    localparam logic [1:0] SelIdle = 2'b00;
    localparam logic [1:0] SelAct1 = 2'b10;
    localparam logic [1:0] SelAct2 = 2'b11;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        STREAM = 3'd1,
        LOAD   = 3'd2,
        DRIVE  = 3'd3,
        TURN   = 3'd4,
        FIN    = 3'd5
    } act_state_e;

    // src 0 = neighbour 1 (act1), src 1 = neighbour 2 (act2)
    function automatic logic [1:0] sel_for(input logic src);
        return src ? SelAct2 : SelAct1;
    endfunction

endpackage

// File: rtl/act_rr_arb.sv
// Two-way round-robin arbiter; priority flips to the other port after each
// grant that is actually taken.
module act_rr_arb
    import act_sched_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic req1,
    input  logic req2,
    input  logic take,
    output logic gnt1,
    output logic gnt2
);

    logic ptr; // 0: port 1 wins a tie, 1: port 2 wins a tie

    always_comb begin
        gnt1 = 1'b0;
        gnt2 = 1'b0;
        if (req1 && (!req2 || !ptr)) begin
            gnt1 = 1'b1;
        end else if (req2) begin
            gnt2 = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr <= 1'b0;
        end else if (take && gnt1) begin
            ptr <= 1'b1;
        end else if (take && gnt2) begin
            ptr <= 1'b0;
        end
    end

endmodule

// File: rtl/act_sched.sv
// Sequencer/arbiter for the shared ReLU activation unit between act1 and act2.
// All outputs are registered: each output flop holds f(next state).
module act_sched
    import act_sched_pkg::*;
#(
    parameter int LenWidth = LenWidthDef
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                req1,
    input  logic                dst1,
    input  logic [LenWidth-1:0] len1,
    input  logic                req2,
    input  logic                dst2,
    input  logic [LenWidth-1:0] len2,
    output logic                gnt1,
    output logic                gnt2,
    output logic                drv1,
    output logic                drv2,
    output logic [1:0]          sel_i,
    output logic                sel_o1,
    output logic                sel_o2,
    output logic                busy,
    output logic                done,
    output act_state_e          state_dbg
);

    localparam logic [LenWidth-1:0] CntOne = LenWidth'(1);

    act_state_e          state, state_d;
    logic [LenWidth-1:0] cnt, cnt_d;
    logic                src, src_d;
    logic                dst, dst_d;
    logic                take, arb_gnt1, arb_gnt2;
    logic                driving, result;
    logic                gnt1_d, gnt2_d, drv1_d, drv2_d;
    logic                sel_o1_d, sel_o2_d, busy_d, done_d;
    logic [1:0]          sel_i_d;

    act_rr_arb u_arb (
        .clk  (clk),
        .rst  (rst),
        .req1 (req1),
        .req2 (req2),
        .take (take),
        .gnt1 (arb_gnt1),
        .gnt2 (arb_gnt2)
    );

    always_comb begin
        state_d = state;
        cnt_d   = cnt;
        dst_d   = dst;
        unique case (state)
            IDLE: begin
                // Grant cycle: dst/len are taken from the granted port now.
                if (gnt1 || gnt2) begin
                    dst_d = src ? dst2 : dst1;
                    cnt_d = src ? len2 : len1;
                    if (cnt_d == '0) begin
                        state_d = FIN;
                    end else if (dst_d != src) begin
                        state_d = STREAM;
                    end else begin
                        state_d = LOAD;
                    end
                end
            end
            STREAM: begin
                if (cnt == CntOne) state_d = FIN;
                else               cnt_d   = cnt - CntOne;
            end
            LOAD:  state_d = DRIVE;
            DRIVE: state_d = TURN;
            TURN: begin
                if (cnt == CntOne) begin
                    state_d = IDLE;
                end else begin
                    cnt_d   = cnt - CntOne;
                    state_d = LOAD;
                end
            end
            FIN:     state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // A new grant is only issued into an IDLE cycle, so it cannot overlap a burst.
        take   = (state_d == IDLE);
        gnt1_d = take && arb_gnt1;
        gnt2_d = take && arb_gnt2;
        src_d  = src;
        if (gnt2_d)      src_d = 1'b1;
        else if (gnt1_d) src_d = 1'b0;

        driving  = (state_d == STREAM) || (state_d == LOAD);
        drv1_d   = driving && !src;
        drv2_d   = driving && src;
        sel_i_d  = driving ? sel_for(src) : SelIdle;
        // Streaming results trail the bus by one cycle of activation latency.
        result   = (state == STREAM) || (state_d == DRIVE);
        sel_o1_d = result && !dst_d;
        sel_o2_d = result && dst_d;
        busy_d   = (state_d != IDLE);
        done_d   = (state_d == FIN) || ((state_d == DRIVE) && (cnt_d == CntOne));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            src    <= 1'b0;
            dst    <= 1'b0;
            gnt1   <= 1'b0;
            gnt2   <= 1'b0;
            drv1   <= 1'b0;
            drv2   <= 1'b0;
            sel_i  <= SelIdle;
            sel_o1 <= 1'b0;
            sel_o2 <= 1'b0;
            busy   <= 1'b0;
            done   <= 1'b0;
        end else begin
            state  <= state_d;
            cnt    <= cnt_d;
            src    <= src_d;
            dst    <= dst_d;
            gnt1   <= gnt1_d;
            gnt2   <= gnt2_d;
            drv1   <= drv1_d;
            drv2   <= drv2_d;
            sel_i  <= sel_i_d;
            sel_o1 <= sel_o1_d;
            sel_o2 <= sel_o2_d;
            busy   <= busy_d;
            done   <= done_d;
        end
    end

    assign state_dbg = state;

endmodule

// File: tb/tb_act_sched.sv
// Directed and random bench for act_sched: per-cycle expected output vectors in a
// scoreboard queue, a ReLU/bus model for data, and per-cycle bus-safety checks.
module tb_act_sched;
    import act_sched_pkg::*;

    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req1 = 1'b0, dst1 = 1'b0, req2 = 1'b0, dst2 = 1'b0;
    logic [LW-1:0] len1 = '0, len2 = '0;
    logic          gnt1, gnt2, drv1, drv2, sel_o1, sel_o2, busy, done;
    logic [1:0]    sel_i;
    act_state_e    state_dbg;

    int n_checks = 0;
    int n_pass   = 0;
    int n_g      = 0;
    int n_d      = 0;
    logic drained;
    logic seen;

    logic [9:0]        exp_q[$];
    logic signed [7:0] dexp_q[$];

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    act_sched #(.LenWidth(LW)) dut (
        .clk(clk), .rst(rst),
        .req1(req1), .dst1(dst1), .len1(len1),
        .req2(req2), .dst2(dst2), .len2(len2),
        .gnt1(gnt1), .gnt2(gnt2), .drv1(drv1), .drv2(drv2),
        .sel_i(sel_i), .sel_o1(sel_o1), .sel_o2(sel_o2),
        .busy(busy), .done(done), .state_dbg(state_dbg)
    );

    // ---------------- helpers ----------------
    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        assert (got === want) n_pass++;
        else $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    function automatic logic [9:0] vec(input logic g1, input logic g2, input logic d1,
                                       input logic d2, input logic [1:0] si, input logic o1,
                                       input logic o2, input logic b, input logic dn);
        return {g1, g2, d1, d2, si, o1, o2, b, dn};
    endfunction

    function automatic logic [9:0] obs();
        return {gnt1, gnt2, drv1, drv2, sel_i, sel_o1, sel_o2, busy, done};
    endfunction

    // Expected cycles T+1.. of a burst granted at T, followed by 'tail'.
    task automatic push_burst(input logic src, input logic dst, input int len, input logic [9:0] tail);
        logic [1:0] sc;
        sc = src ? 2'b11 : 2'b10;
        if (len == 0) begin
            exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b1));
        end else if (src != dst) begin
            for (int c = 1; c <= len + 1; c++)
                exp_q.push_back(vec(1'b0, 1'b0, !src && c <= len, src && c <= len,
                                    (c <= len) ? sc : 2'b00, !dst && c >= 2, dst && c >= 2,
                                    1'b1, c == len + 1));
        end else begin
            for (int i = 0; i < len; i++) begin
                exp_q.push_back(vec(1'b0, 1'b0, !src, src, sc, 1'b0, 1'b0, 1'b1, 1'b0));
                exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, !src, src, 1'b1, i == len - 1));
                exp_q.push_back(vec(1'b0, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b1, 1'b0));
            end
        end
        exp_q.push_back(tail);
    endtask

    task automatic run_trace(input string tag);
        logic [9:0] e;
        int n;
        n = 1;
        while (exp_q.size() > 0) begin
            @(negedge clk);
            e = exp_q.pop_front();
            chk($sformatf("%s_c%0d", tag, n), 32'(obs()), 32'(e));
            n++;
        end
    endtask

    task automatic wait_grant(input string tag, input logic [9:0] want);
        seen = 1'b0;
        for (int i = 0; i < 40 && !seen; i++) begin
            @(negedge clk);
            if (gnt1 || gnt2) seen = 1'b1;
        end
        chk({tag, "_seen"}, 32'(seen), 32'd1);
        chk({tag, "_gnt"}, 32'(obs()), 32'(want));
    endtask

    // ---------------- bus / activation unit model ----------------
    logic signed [7:0] d1_arr [8] = '{8'sd5, -8'sd2, 8'sd7, 8'sd1, 8'sd1, 8'sd1, 8'sd1, 8'sd1};
    logic signed [7:0] d2_arr [8] = '{-8'sd3, 8'sd9, 8'sd2, 8'sd2, 8'sd2, 8'sd2, 8'sd2, 8'sd2};
    logic [2:0]        i1, i2;
    logic signed [7:0] act_in, pst, act1, act2, dexp;

    assign pst  = (act_in > 0) ? act_in : 8'sd0;
    assign act1 = drv1 ? d1_arr[i1] : (sel_o1 ? pst : 8'sd0);
    assign act2 = drv2 ? d2_arr[i2] : (sel_o2 ? pst : 8'sd0);

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            i1 = '0;
            i2 = '0;
            act_in = 8'sd0;
        end else begin
            if ((sel_o1 || sel_o2) && dexp_q.size() > 0) begin
                dexp = dexp_q.pop_front();
                chk("rx_data", 32'(sel_o1 ? act1 : act2), 32'(dexp));
            end
            act_in = (sel_i == 2'b10) ? act1 : (sel_i == 2'b11) ? act2 : 8'sd0;
            if (drv1) i1 = i1 + 3'd1;
            if (drv2) i2 = i2 + 3'd1;
        end
    end

    // ---------------- bus-safety checks ----------------
    logic prev_o1, prev_o2;
    always @(negedge clk or posedge rst) begin
        if (rst) begin
            prev_o1 = 1'b0;
            prev_o2 = 1'b0;
        end else begin
            chk("contend", 32'((drv1 && sel_o1) || (drv2 && sel_o2)), 32'd0);
            chk("two_sel_o", 32'(sel_o1 && sel_o2), 32'd0);
            chk("sel_i_drv", 32'((sel_i == 2'b10 && !drv1) || (sel_i == 2'b11 && !drv2) ||
                                 (sel_i == 2'b01)), 32'd0);
            chk("turnaround", 32'((prev_o1 && !sel_o1 && drv1) || (prev_o2 && !sel_o2 && drv2)), 32'd0);
            prev_o1 = sel_o1;
            prev_o2 = sel_o2;
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        @(negedge clk);
        chk("reset_outputs", 32'(obs()), 32'd0);
        chk("reset_state", 32'(state_dbg), 32'(IDLE));
        rst = 1'b0;

        // stream: port1 -> act2, L=3
        @(negedge clk);
        dexp_q.push_back(8'sd5);
        dexp_q.push_back(8'sd0);
        dexp_q.push_back(8'sd7);
        req1 = 1'b1; dst1 = 1'b1; len1 = 8'd3;
        wait_grant("stream", vec(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        req1 = 1'b0;
        push_burst(1'b0, 1'b1, 3, '0);
        run_trace("stream");
        chk("stream_rx_all", 32'(dexp_q.size()), 32'd0);

        // echo: port2 -> act2, L=2
        dexp_q.push_back(8'sd0);
        dexp_q.push_back(8'sd9);
        req2 = 1'b1; dst2 = 1'b1; len2 = 8'd2;
        wait_grant("echo", vec(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        req2 = 1'b0;
        push_burst(1'b1, 1'b1, 2, '0);
        run_trace("echo");
        chk("echo_idle_state", 32'(state_dbg), 32'(IDLE));
        chk("echo_rx_all", 32'(dexp_q.size()), 32'd0);

        // round robin: both pending from reset
        rst = 1'b1;
        req1 = 1'b1; dst1 = 1'b1; len1 = 8'd1;
        req2 = 1'b1; dst2 = 1'b0; len2 = 8'd1;
        @(negedge clk);
        rst = 1'b0;
        wait_grant("rr1", vec(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        req1 = 1'b0;
        push_burst(1'b0, 1'b1, 1, vec(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        run_trace("rr1");
        req1 = 1'b1;
        push_burst(1'b1, 1'b0, 1, vec(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        run_trace("rr2");
        req1 = 1'b0;
        push_burst(1'b0, 1'b1, 1, vec(1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        run_trace("rr3");
        req2 = 1'b0;
        push_burst(1'b1, 1'b0, 1, '0);
        run_trace("rr4");

        // zero-length burst
        req1 = 1'b1; dst1 = 1'b0; len1 = 8'd0;
        wait_grant("len0", vec(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        req1 = 1'b0;
        push_burst(1'b0, 1'b0, 0, '0);
        run_trace("len0");

        // reset mid-stream
        req1 = 1'b1; dst1 = 1'b1; len1 = 8'd5;
        wait_grant("midrst", vec(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        req1 = 1'b0;
        @(negedge clk);
        @(negedge clk);
        chk("midrst_active", 32'(drv1 && sel_o2), 32'd1);
        rst = 1'b1;
        #1;
        chk("midrst_async_out", 32'(obs()), 32'd0);
        chk("midrst_async_state", 32'(state_dbg), 32'(IDLE));
        @(negedge clk);
        chk("midrst_held", 32'(obs()), 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk($sformatf("midrst_quiet%0d", i), 32'(obs()), 32'd0);
        end
        req1 = 1'b1; dst1 = 1'b1; len1 = 8'd2;
        wait_grant("postrst", vec(1'b1, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 1'b0, 1'b0, 1'b0));
        req1 = 1'b0;
        push_burst(1'b0, 1'b1, 2, '0);
        run_trace("postrst");

        // random traffic
        drained = 1'b0;
        for (int cyc = 0; cyc < 10400 && !drained; cyc++) begin
            @(negedge clk);
            if (gnt1) n_g++;
            if (gnt2) n_g++;
            if (done) n_d++;
            if (gnt1) begin
                req1 = 1'b0;
            end else if (!req1 && cyc < 10000 && $urandom_range(0, 7) == 0) begin
                req1 = 1'b1;
                len1 = 8'($urandom_range(0, 6));
                dst1 = 1'($urandom_range(0, 1));
            end
            if (gnt2) begin
                req2 = 1'b0;
            end else if (!req2 && cyc < 10000 && $urandom_range(0, 7) == 0) begin
                req2 = 1'b1;
                len2 = 8'($urandom_range(0, 6));
                dst2 = 1'($urandom_range(0, 1));
            end
            if (cyc >= 10000 && !req1 && !req2 && !busy && !gnt1 && !gnt2) drained = 1'b1;
        end
        chk("rand_drained", 32'(drained), 32'd1);
        chk("rand_done_eq_gnt", 32'(n_d), 32'(n_g));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
